// File: rtl/ahbl_splitter_n.sv
// ahbl_splitter_n -- AHB-Lite one-master to NS-slave splitter with built-in
// default slave.
//
// Address decode uses HADDR[31:28]. Slave i owns page PAGES[4i+3:4i]. When
// pages overlap, the lowest matching index wins. A one-hot data-phase select
// register steers HREADY/HRDATA/HRESP back from the addressed slave.
//
// NONSEQ/SEQ transfers that hit no page go to an internal default slave. It
// gives the two-cycle AHB ERROR response and records each such access in
// ERR_CNT (saturating) and ERR_ADDR.
//
// Ports:
//   HCLK, HRESETn        clock, async active-low reset
//   HADDR, HTRANS        master address phase
//   HREADY, HRDATA, HRESP
//                        muxed data-phase response. HREADY also goes to every
//                        slave.
//   S_HSEL               per-slave select (combinational from HADDR)
//   S_HRDATA, S_HREADYOUT, S_HRESP
//                        per-slave responses; slave i data is in [32i+31:32i]
//   ERR_CNT, ERR_ADDR    unmapped-access count and the last unmapped address

// Per-slave page decoder; a chain of these gives the lowest-index priority.
module ahbl_splitter_n_dec #(
  parameter logic [3:0] PAGE = 4'h0
) (
  input  logic [3:0] pg,
  input  logic       hit_lo,   // some lower index already matched
  output logic       hsel,
  output logic       hit_hi    // this or any lower index matched
);
  logic match;
  assign match  = (pg == PAGE);
  assign hsel   = match & ~hit_lo;
  assign hit_hi = match | hit_lo;
endmodule

module ahbl_splitter_n #(
  parameter int          NS       = 4,
  parameter logic [31:0] PAGES    = 32'h0000_8420,
  parameter logic [31:0] ERR_DATA = 32'hBADD_BEEF
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic             HREADY,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  output logic [NS-1:0]    S_HSEL,
  input  logic [32*NS-1:0] S_HRDATA,
  input  logic [NS-1:0]    S_HREADYOUT,
  input  logic [NS-1:0]    S_HRESP,
  output logic [7:0]       ERR_CNT,
  output logic [31:0]      ERR_ADDR
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} st_t;

  st_t          state, state_nxt;
  logic [NS:0]  hit;
  logic [NS-1:0] sel_q;
  logic         err_acc;
  logic         fsm_rdy, fsm_rsp;
  logic         rdy_mux, rsp_mux;
  logic [31:0]  rd_mux;
  logic         unused_addr;

  // Only the page nibble and HTRANS[1] matter for decode.
  assign unused_addr = ^{HADDR[27:0], HTRANS[0]};

  // ---------------- address decode ----------------
  assign hit[0] = 1'b0;
  for (genvar i = 0; i < NS; i++) begin : g_dec
    ahbl_splitter_n_dec #(.PAGE(PAGES[4*i +: 4])) u_dec (
      .pg     (HADDR[31:28]),
      .hit_lo (hit[i]),
      .hsel   (S_HSEL[i]),
      .hit_hi (hit[i+1])
    );
  end

  // An unmapped NONSEQ/SEQ is accepted this cycle.
  assign err_acc = HREADY & HTRANS[1] & ~hit[NS];

  // ---------------- data-phase select ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= HTRANS[1] ? S_HSEL : '0;
  end

  // ---------------- default-slave FSM ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (err_acc) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = err_acc ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // These outputs depend only on the registered state. This keeps HREADY from
  // looping back into HREADY.
  always_comb begin
    fsm_rdy = (state != ERR1);
    fsm_rsp = (state != IDLE);
  end

  // ---------------- error log ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_CNT  <= '0;
      ERR_ADDR <= '0;
    end else if (err_acc) begin
      ERR_ADDR <= HADDR;
      if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

  // ---------------- response mux ----------------
  // sel_q is one-hot or zero, so an AND-OR mux is enough.
  always_comb begin
    rd_mux  = '0;
    rdy_mux = 1'b0;
    rsp_mux = 1'b0;
    for (int i = 0; i < NS; i++) begin
      rd_mux  = rd_mux  | ({32{sel_q[i]}} & S_HRDATA[32*i +: 32]);
      rdy_mux = rdy_mux | (sel_q[i] & S_HREADYOUT[i]);
      rsp_mux = rsp_mux | (sel_q[i] & S_HRESP[i]);
    end
  end

  // A nonzero sel_q only exists while the FSM is in IDLE. An unmapped
  // acceptance always loads zero into sel_q.
  always_comb begin
    if (|sel_q) begin
      HREADY = rdy_mux;
      HRESP  = rsp_mux;
      HRDATA = rd_mux;
    end else begin
      HREADY = fsm_rdy;
      HRESP  = fsm_rsp;
      HRDATA = ERR_DATA;
    end
  end

endmodule

// File: tb/tb_ahbl_splitter_n.sv
module tb_ahbl_splitter_n;

  logic         HCLK, HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HREADY, HRESP;
  logic [31:0]  HRDATA;
  logic [3:0]   S_HSEL, S_HREADYOUT, S_HRESP;
  logic [127:0] S_HRDATA;
  logic [7:0]   ERR_CNT;
  logic [31:0]  ERR_ADDR;

  // Overlapping-page instance (NS=2, both slaves own page 1).
  logic         o_hready, o_hresp;
  logic [31:0]  o_hrdata;
  logic [1:0]   o_hsel;
  logic [7:0]   o_cnt;
  logic [31:0]  o_eaddr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BAD = 32'hBADD_BEEF;

  ahbl_splitter_n u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR)
  );

  ahbl_splitter_n #(.NS(2), .PAGES(32'h0000_0011)) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(o_hready), .HRDATA(o_hrdata), .HRESP(o_hresp), .S_HSEL(o_hsel),
    .S_HRDATA(64'h0202_0202_0101_0101), .S_HREADYOUT(2'b11), .S_HRESP(2'b00),
    .ERR_CNT(o_cnt), .ERR_ADDR(o_eaddr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  rdy, rsp, sel;
    logic        hrdy, hrsp;
    logic [31:0] data;
    logic [7:0]  cnt;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] t,
                              input logic [3:0] rdy, input logic [3:0] rsp,
                              input logic [3:0] sel, input logic hrdy,
                              input logic hrsp, input logic [31:0] d,
                              input logic [7:0] c, input logic [31:0] ea);
    vec_t v;
    v.addr = a; v.trans = t; v.rdy = rdy; v.rsp = rsp; v.sel = sel;
    v.hrdy = hrdy; v.hrsp = hrsp; v.data = d; v.cnt = c; v.eaddr = ea;
    return v;
  endfunction

  vec_t vt[16];

  initial begin
    // One vector per clock. Inputs are driven at the start of the cycle and
    // outputs are checked before the next edge. Outputs reflect the
    // previously accepted address phase.
    //          addr          tr    rdy      rsp      sel      rdy  rsp  data           cnt  eaddr
    vt[0]  = mk(32'h2000_0010, 2'd2, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, BAD,          8'd0, 32'h0);
    vt[1]  = mk(32'h4000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 32'h1234_5678, 8'd0, 32'h0);
    vt[2]  = mk(32'h3000_0000, 2'd2, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h2222_2222, 8'd0, 32'h0);
    vt[3]  = mk(32'h3000_0000, 2'd2, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h2222_2222, 8'd0, 32'h0);
    vt[4]  = mk(32'h3000_0000, 2'd2, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h2222_2222, 8'd0, 32'h0);
    vt[5]  = mk(32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h2222_2222, 8'd0, 32'h0);
    vt[6]  = mk(32'h3000_0004, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, BAD,          8'd0, 32'h0);
    vt[7]  = mk(32'h5000_0000, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, BAD,          8'd1, 32'h3000_0004);
    vt[8]  = mk(32'h3000_0008, 2'd2, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, BAD,          8'd1, 32'h3000_0004);
    vt[9]  = mk(32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, BAD,          8'd2, 32'h3000_0008);
    vt[10] = mk(32'h3000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, BAD,          8'd2, 32'h3000_0008);
    vt[11] = mk(32'h3000_0000, 2'd1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, BAD,          8'd2, 32'h3000_0008);
    vt[12] = mk(32'h0000_0040, 2'd3, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, BAD,          8'd2, 32'h3000_0008);
    vt[13] = mk(32'h8000_0000, 2'd2, 4'b1111, 4'b0001, 4'b1000, 1'b1, 1'b1, 32'hA0A0_0000, 8'd2, 32'h3000_0008);
    vt[14] = mk(32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h3333_3333, 8'd2, 32'h3000_0008);
    vt[15] = mk(32'h0000_0000, 2'd0, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, BAD,          8'd2, 32'h3000_0008);

    S_HRDATA    = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hA0A0_0000};
    S_HREADYOUT = 4'b1111;
    S_HRESP     = 4'b0000;
    HADDR       = 32'h0;
    HTRANS      = 2'd0;
    HRESETn     = 1'b0;

    // Reset state
    #2;
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, BAD);
    chk("rst_cnt", ERR_CNT, 8'd0);
    chk("rst_eaddr", ERR_ADDR, 32'h0);
    #20 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      HADDR = vt[i].addr; HTRANS = vt[i].trans;
      S_HREADYOUT = vt[i].rdy; S_HRESP = vt[i].rsp;
      #2;
      chk($sformatf("v%0d_hsel", i), S_HSEL, vt[i].sel);
      chk($sformatf("v%0d_hready", i), HREADY, vt[i].hrdy);
      chk($sformatf("v%0d_hresp", i), HRESP, vt[i].hrsp);
      chk($sformatf("v%0d_hrdata", i), HRDATA, vt[i].data);
      chk($sformatf("v%0d_cnt", i), ERR_CNT, vt[i].cnt);
      chk($sformatf("v%0d_eaddr", i), ERR_ADDR, vt[i].eaddr);
      @(posedge HCLK); #1;
    end

    // Saturation: 600 cycles of unmapped NONSEQ give 300 more acceptances.
    S_HREADYOUT = 4'b1111; S_HRESP = 4'b0000;
    HADDR = 32'h3000_0000; HTRANS = 2'd2;
    for (int i = 0; i < 600; i++) begin
      @(posedge HCLK); #1;
    end
    chk("sat_cnt", ERR_CNT, 8'hFF);
    chk("sat_err2_hready", HREADY, 1'b1);
    chk("sat_err2_hresp", HRESP, 1'b1);
    @(posedge HCLK); #1;
    chk("sat_err1_hready", HREADY, 1'b0);
    chk("sat_cnt_hold", ERR_CNT, 8'hFF);

    // Async reset while in ERR1
    #2 HRESETn = 1'b0; HTRANS = 2'd0;
    #1;
    chk("err1_rst_hready", HREADY, 1'b1);
    chk("err1_rst_hresp", HRESP, 1'b0);
    chk("err1_rst_hrdata", HRDATA, BAD);
    chk("err1_rst_cnt", ERR_CNT, 8'd0);
    chk("err1_rst_eaddr", ERR_ADDR, 32'h0);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("post_rst_hready", HREADY, 1'b1);
    chk("post_rst_hresp", HRESP, 1'b0);

    // Async reset in the middle of a slave wait state
    HADDR = 32'h4000_0000; HTRANS = 2'd2; S_HREADYOUT = 4'b1011;
    @(posedge HCLK); #1;
    HTRANS = 2'd0;
    #1;
    chk("wait_hready", HREADY, 1'b0);
    #1 HRESETn = 1'b0;
    #1;
    chk("wait_rst_hready", HREADY, 1'b1);
    chk("wait_rst_hrdata", HRDATA, BAD);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("wait_post_hready", HREADY, 1'b1);
    S_HREADYOUT = 4'b1111;

    // Overlapping pages: only the lowest index is selected
    HADDR = 32'h1000_0000; HTRANS = 2'd2;
    #1;
    chk("ovl_hsel", o_hsel, 2'b01);
    chk("main_hsel_unmapped", S_HSEL, 4'b0000);
    @(posedge HCLK); #1;
    HTRANS = 2'd0;
    #1;
    chk("ovl_hrdata", o_hrdata, 32'h0101_0101);
    chk("ovl_hready", o_hready, 1'b1);
    chk("main_unmapped_cnt", ERR_CNT, 8'd1);
    chk("main_unmapped_eaddr", ERR_ADDR, 32'h1000_0000);
    chk("main_unmapped_hready", HREADY, 1'b0);
    @(posedge HCLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_splitter_n.md
AHBL_SPLITTER_N -- requirements
Module: ahbl_splitter_n

Interface
REQ-001 SHALL have parameter NS, default 4, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter PAGES, default 32'h0000_8420, packed 4-bit page IDs; slave i owns page PAGES[4i+3:4i].
REQ-003 SHALL have parameter ERR_DATA, default 32'hBADD_BEEF, HRDATA value when no slave is in data phase.
REQ-004 SHALL have port HCLK  in  1  bus clock, all state on rising edge.
REQ-005 SHALL have port HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port HADDR  in  32  master address-phase address.
REQ-007 SHALL have port HTRANS  in  2  master transfer type; bit 1 set = NONSEQ/SEQ.
REQ-008 SHALL have port HREADY  out  32→1  bus ready, returned to master and all slaves (width 1).
REQ-009 SHALL have port HRDATA  out  32  muxed read data.
REQ-010 SHALL have port HRESP  out  1  muxed response, 1 = ERROR.
REQ-011 SHALL have port S_HSEL  out  NS  per-slave select.
REQ-012 SHALL have port S_HRDATA  in  32*NS  slave read data; slave i in bits [32i+31:32i].
REQ-013 SHALL have port S_HREADYOUT  in  NS  per-slave ready.
REQ-014 SHALL have port S_HRESP  in  NS  per-slave response.
REQ-015 SHALL have port ERR_CNT  out  8  saturating count of unmapped accesses.
REQ-016 SHALL have port ERR_ADDR  out  32  address of most recent unmapped access.

Function
REQ-017 S_HSEL[i] SHALL be combinational: 1 when HADDR[31:28]==page i; on overlapping pages only the lowest matching index asserts.
REQ-018 S_HSEL SHALL not depend on HTRANS; slaves qualify with HTRANS and HREADY.
REQ-019 Address-phase acceptance = HREADY==1 at a rising edge; a data-phase select register (one-hot, NS bits) SHALL load on every acceptance.
REQ-020 On acceptance with HTRANS[1]==1 and a match, select register SHALL load the one-hot match; otherwise it SHALL load all-zero.
REQ-021 Select register nonzero: HREADY, HRDATA, HRESP SHALL equal the selected slave's S_HREADYOUT, S_HRDATA slice, S_HRESP.
REQ-022 Select register zero and default FSM in IDLE: HREADY=1, HRESP=0, HRDATA=ERR_DATA.
REQ-023 Default-slave FSM states: IDLE, ERR1, ERR2.
REQ-024 IDLE→ERR1 on acceptance with HTRANS[1]==1 and no match; else stay IDLE.
REQ-025 ERR1: HREADY=0, HRESP=1; next state ERR2 unconditionally.
REQ-026 ERR2: HREADY=1, HRESP=1; next state ERR1 if this cycle accepts another unmapped NONSEQ/SEQ, else IDLE.
REQ-027 Address-phase changes by master during ERR1 (HREADY=0) SHALL not be captured.
REQ-028 On each unmapped NONSEQ/SEQ acceptance, ERR_ADDR SHALL load HADDR and ERR_CNT SHALL increment, holding at 8'hFF.
REQ-029 IDLE/BUSY transfers to unmapped addresses SHALL give zero-wait OKAY and SHALL not touch ERR_CNT/ERR_ADDR.
REQ-030 Combinational paths SHALL run only HADDR→S_HSEL and slave inputs→HREADY/HRDATA/HRESP; no HREADY→HREADY loop through the FSM.

Reset
REQ-031 HRESETn low SHALL asynchronously set select register to 0, FSM to IDLE, ERR_CNT=0, ERR_ADDR=0.
REQ-032 During and after reset until first acceptance: HREADY=1, HRESP=0, HRDATA=ERR_DATA.
REQ-033 Reset asserted in ERR1/ERR2 or mid slave wait state SHALL abort the transfer; first post-reset cycle shows REQ-032 outputs.

Verification
REQ-034 NONSEQ read 0x2000_0010, S1 HREADYOUT=1, S_HRDATA slice 1=0x1234_5678 -> S_HSEL=0010 in addr phase; next cycle HRDATA=0x1234_5678, HREADY=1, HRESP=0.
REQ-035 NONSEQ to 0x4000_0000, S2 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for exactly 3 data-phase cycles; next address not captured until HREADY=1.
REQ-036 NONSEQ to 0x3000_0004 -> HREADY/HRESP = 0/1 then 1/1; ERR_CNT=1, ERR_ADDR=0x3000_0004; back-to-back unmapped NONSEQ in ERR2 -> ERR1 again, ERR_CNT=2.
REQ-037 IDLE to 0x3000_0000 -> HREADY=1, HRESP=0, HRDATA=0xBADD_BEEF, ERR_CNT unchanged.
REQ-038 300 unmapped NONSEQ accesses -> ERR_CNT=0xFF; HRESETn pulse in ERR1 -> FSM IDLE, ERR_CNT=0, HREADY=1 immediately.
REQ-039 NS=2, PAGES=8'h11 (overlap) -> access to 0x1xxx_xxxx selects only S_HSEL[0].
